// File: rtl/keychain_pkg.sv
// keychain_pkg: shared types and helpers for the keychain UART transmit path.
//   tx_state_t : frame-level line state (IDLE, START, DATA, STOP)
//   baud_div   : clock cycles per UART bit (integer division)
//   cnt_width  : register width able to hold 0..n-1, never narrower than 1 bit
package keychain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int BITS_PER_BYTE = 8;

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: sends one 8N1 frame (start bit 0, 8 data bits LSB first,
// stop bit 1), each bit held for exactly BAUD_DIV clock cycles.
//
// Ports
//   clk_in     in   1   system clock, posedge
//   rst_n_in   in   1   synchronous active-low reset
//   byte_in    in   8   byte to send, sampled on acceptance
//   valid_in   in   1   byte_in valid
//   ready_out  out  1   may accept a byte this cycle
//   tx_out     out  1   registered UART line, idle high
//   state_out  out  2   current tx_state_t, for observation
//
// Handshake: a byte is transferred on a rising clk_in edge where both
// valid_in and ready_out are high. ready_out is high in IDLE and also in the
// final cycle of STOP, so a byte offered then starts its START bit on the
// very next cycle with no idle gap between frames. ready_out is low during
// reset.
module uart_tx_byte
  import keychain_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic [1:0] state_out
);

  localparam int              CNT_W    = cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  // Last cycle of the current bit period; the baud counter wraps here.
  assign bit_end   = (baud_cnt == CNT_LAST);
  assign ready_out = rst_n_in && ((state == IDLE) || ((state == STOP) && bit_end));
  assign state_out = state;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx_out   <= 1'b1;
          if (valid_in) begin
            shreg  <= byte_in;
            state  <= START;
            tx_out <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx_out   <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        // shreg[0] is always the bit currently on the line; shifting right
        // at each bit boundary brings the next bit into position.
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state  <= STOP;
              tx_out <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_out  <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (valid_in) begin
              shreg  <= byte_in;
              state  <= START;
              tx_out <= 1'b0;
            end else begin
              state  <= IDLE;
              tx_out <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/msg_uart_tx.sv
// msg_uart_tx: accepts one MSG_BYTES-wide word and sends it as MSG_BYTES
// back-to-back 8N1 frames, most-significant byte first.
//
// Ports
//   clk_in       in   1            system clock, posedge
//   rst_n_in     in   1            synchronous active-low reset
//   data_in      in   8*MSG_BYTES  word to send, sampled on acceptance
//   valid_in     in   1            data_in valid
//   ready_out    out  1            word may be accepted this cycle
//   busy_out     out  1            word in flight (registered)
//   tx_wire_out  out  1            UART line, idle high (registered)
//
// Handshake: a word is accepted on a rising clk_in edge where valid_in and
// ready_out are both high. ready_out is high only while no word is in flight
// and rst_n_in is high. data_in/valid_in are ignored while busy.
module msg_uart_tx
  import keychain_pkg::*;
#(
  parameter int MSG_BYTES = 2,
  parameter int BAUD_RATE = 115_200,
  parameter int CLK_FREQ  = 100_000_000
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [8*MSG_BYTES-1:0] data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic                   busy_out,
  output logic                   tx_wire_out
);

  localparam int               WORD_W   = BITS_PER_BYTE * MSG_BYTES;
  localparam int               BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int               IDX_W    = cnt_width(MSG_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_BYTES - 1);

  logic [WORD_W-1:0] shift_r;
  logic [IDX_W-1:0]  byte_idx;
  logic              busy_r;

  logic              accept;
  logic              more_bytes;
  logic              byte_valid;
  logic              byte_ready;
  logic              last_stop;
  logic [7:0]        byte_data;
  logic [1:0]        byte_state;

  assign ready_out  = rst_n_in && !busy_r;
  assign accept     = valid_in && ready_out;
  assign more_bytes = (byte_idx != IDX_LAST);

  // The first byte goes straight from data_in to the frame engine on the
  // accepting edge so START begins the following cycle. Later bytes are
  // offered from the shift register and taken in the last STOP cycle.
  assign byte_valid = accept || (busy_r && more_bytes);
  assign byte_data  = accept ? data_in[WORD_W-1 -: 8] : shift_r[WORD_W-1 -: 8];

  // Final cycle of a stop bit: the frame engine either takes the next byte
  // or falls back to IDLE on this edge.
  assign last_stop  = byte_ready && (tx_state_t'(byte_state) == STOP);

  assign busy_out   = busy_r;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      shift_r  <= '0;
      byte_idx <= '0;
      busy_r   <= 1'b0;
    end else if (accept) begin
      // Byte 0 is already in flight; keep the remaining bytes MSB-aligned.
      shift_r  <= data_in << 8;
      byte_idx <= '0;
      busy_r   <= 1'b1;
    end else if (busy_r && last_stop) begin
      if (more_bytes) begin
        shift_r  <= shift_r << 8;
        byte_idx <= byte_idx + IDX_W'(1);
      end else begin
        busy_r   <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .byte_in   (byte_data),
    .valid_in  (byte_valid),
    .ready_out (byte_ready),
    .tx_out    (tx_wire_out),
    .state_out (byte_state)
  );

endmodule
